wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, consecutive cycles a buffered long-latency result may lose arbitration before it is forced through (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 pipe_valid_i / pipe_ready_o  input / output  1 / 1  in-order pipeline write-back handshake.
REQ-005 pipe_rd_i / pipe_data_i  input  INSTR_REG_SIZE / WD_SIZE  pipeline destination register and write data.
REQ-006 lu_valid_i / lu_ready_o  input / output  1 / 1  long-latency unit (mul/div, late load) result handshake.
REQ-007 lu_rd_i / lu_data_i  input  INSTR_REG_SIZE / WD_SIZE  long-latency destination register and data.
REQ-008 rf_we_o / rf_rd_o / rf_data_o  output  1 / INSTR_REG_SIZE / WD_SIZE  single register-file write port.
REQ-009 lu_pending_o  output  1  high while the long-latency buffer is non-empty, for the scoreboard.

Function
REQ-010 A transfer on either requester occurs when valid and ready are both high at a rising edge.
REQ-011 Long-latency results enter a 2-entry FIFO; lu_ready_o = (count < 2), with no combinational dependence on the grant.
REQ-012 A push into a full FIFO cannot occur; push and pop with count 1 occur in the same cycle, and count stays 1.
REQ-013 FSM states: PIPE_PRI and FORCE_LU.
REQ-014 In PIPE_PRI: pipe_ready_o = 1; if pipe_valid_i is high, the pipeline is granted; otherwise the FIFO head is granted if the FIFO is non-empty.
REQ-015 starve_cnt increments each cycle the FIFO is non-empty and the head is not granted, and clears when the head is granted or the FIFO is empty.
REQ-016 When starve_cnt equals STARVE_MAX at a rising edge, the next state is FORCE_LU.
REQ-017 In FORCE_LU: pipe_ready_o = 0, the FIFO head is granted, starve_cnt clears, and the next state is PIPE_PRI, giving exactly one forced grant per entry.
REQ-018 The granted request drives rf_we_o, rf_rd_o and rf_data_o, registered with 1-cycle latency from the grant edge.
REQ-019 When nothing is granted: rf_we_o = 0 next cycle; rf_rd_o and rf_data_o hold their values.
REQ-020 The order of writes from the same requester is preserved; cross-requester same-rd ordering is the scoreboard's responsibility.
REQ-021 starve_cnt saturates and never wraps.

Reset
REQ-022 With reset_n low, the following take effect immediately and asynchronously: rf_we_o = 0, rf_rd_o = 0, rf_data_o = 0, FIFO empty, lu_pending_o = 0, starve_cnt = 0, state PIPE_PRI.
REQ-023 Reset asserted mid-operation discards buffered results; there is no replay.
REQ-024 The first grant is possible at the first rising edge after reset_n rises.

Configuration
REQ-025 With macro WB_ARB_X0_FILTER_EN defined, a granted write with rd == 0 completes its handshake and pops the FIFO, but rf_we_o stays 0.
REQ-026 Without WB_ARB_X0_FILTER_EN, rd == 0 writes pass through unchanged with rf_we_o = 1.

Structure
REQ-027 WD_SIZE and INSTR_REG_SIZE come from PARAMS_pkg.
REQ-028 The FSM state enum (wb_arb_state_t) and the FIFO entry struct {rd, data} are added to PARAMS_pkg.
REQ-029 The 2-entry FIFO is a sub-module named wb_lu_fifo (push/pop/full/empty/head); arbitration, FSM and output register stay in wb_port_arbiter.

Verification
REQ-030 Pipe only: pipe_valid_i = 1, rd = 5, data = 0xA5A5A5A5 -> rf_we_o = 1, rf_rd_o = 5, rf_data_o = 0xA5A5A5A5 one cycle later; lu_pending_o = 0.
REQ-031 Starvation (STARVE_MAX = 4): pipe_valid_i held high, one LU push rd = 7 at cycle 0 -> pipe_ready_o low exactly in cycle 5, rf_rd_o = 7 in cycle 6, pipe resumes in cycle 6.
REQ-032 FIFO full: two LU pushes (rd = 3, 4) while the pipe is busy -> lu_ready_o = 0; a third push waits; drain order at rf_rd_o is 3 then 4.
REQ-033 Simultaneous push/pop: FIFO count 1, pipe idle, LU push -> head written, count stays 1, lu_ready_o stays 1.
REQ-034 x0: pipe write to rd = 0 -> rf_we_o = 0 with WB_ARB_X0_FILTER_EN; rf_we_o = 1 without it.
REQ-035 Reset mid-operation: FIFO holding 2 entries, reset_n pulsed low between edges -> rf_we_o = 0 immediately, lu_pending_o = 0, and no stale write after release.

Source files
------------

// File: rtl/PARAMS_pkg.sv
// Shared widths and types for the write-back port arbiter and its
// long-latency result FIFO.
package PARAMS_pkg;

    localparam int WD_SIZE        = 32;
    localparam int INSTR_REG_SIZE = 5;

    // Width of the starvation counter; covers STARVE_MAX up to 15.
    localparam int STARVE_W = 4;

    // Arbiter FSM: pipeline has priority, or the buffered head is forced through.
    typedef enum logic {
        PIPE_PRI = 1'b0,
        FORCE_LU = 1'b1
    } wb_arb_state_t;

    // One buffered long-latency result.
    typedef struct packed {
        logic [INSTR_REG_SIZE-1:0] rd;
        logic [WD_SIZE-1:0]        data;
    } wb_lu_entry_t;

endpackage

// File: rtl/wb_lu_fifo.sv
// Two-entry FIFO holding long-latency results until they win the
// register-file write port. Push into a full FIFO and pop from an empty
// one are ignored.
module wb_lu_fifo
    import PARAMS_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  wb_lu_entry_t push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output wb_lu_entry_t head_o
);

    wb_lu_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         push_ok;
    logic         pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 2'd1;
        end
    end

    // Entry storage, written on accepted pushes.
    // NOTE: storage has no reset; the pointers and count define validity, so stale data is never read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// pipeline (priority) and buffered long-latency results, forcing a
// buffered result through after STARVE_MAX consecutive losses.
// Optional macro WB_ARB_X0_FILTER_EN: granted writes to rd == 0 complete
// their handshake but do not assert rf_we_o.
module wb_port_arbiter
    import PARAMS_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      pipe_valid_i,
    output logic                      pipe_ready_o,
    input  logic [INSTR_REG_SIZE-1:0] pipe_rd_i,
    input  logic [WD_SIZE-1:0]        pipe_data_i,
    input  logic                      lu_valid_i,
    output logic                      lu_ready_o,
    input  logic [INSTR_REG_SIZE-1:0] lu_rd_i,
    input  logic [WD_SIZE-1:0]        lu_data_i,
    output logic                      rf_we_o,
    output logic [INSTR_REG_SIZE-1:0] rf_rd_o,
    output logic [WD_SIZE-1:0]        rf_data_o,
    output logic                      lu_pending_o
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    wb_arb_state_t             state_q;
    logic                      pipe_ready_q;
    logic [STARVE_W-1:0]       starve_q;
    logic [STARVE_W-1:0]       starve_d;
    logic                      rf_we_q;
    logic [INSTR_REG_SIZE-1:0] rf_rd_q;
    logic [WD_SIZE-1:0]        rf_data_q;

    logic         fifo_full;
    logic         fifo_empty;
    wb_lu_entry_t fifo_head;
    wb_lu_entry_t lu_entry;
    wb_lu_entry_t gnt_entry;
    logic         lu_push;
    logic         pipe_gnt;
    logic         lu_gnt;
    logic         gnt_we;

    assign lu_entry     = '{rd: lu_rd_i, data: lu_data_i};
    assign lu_push      = lu_valid_i & ~fifo_full;
    assign lu_ready_o   = ~fifo_full;
    assign lu_pending_o = ~fifo_empty;
    assign pipe_ready_o = pipe_ready_q;
    assign rf_we_o      = rf_we_q;
    assign rf_rd_o      = rf_rd_q;
    assign rf_data_o    = rf_data_q;

    wb_lu_fifo u_lu_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (lu_push),
        .push_data_i (lu_entry),
        .pop_i       (lu_gnt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    // Grant selection: forced head in FORCE_LU, else pipeline first, else FIFO head.
    always_comb begin
        pipe_gnt = 1'b0;
        lu_gnt   = 1'b0;
        if (state_q == FORCE_LU) begin
            lu_gnt = ~fifo_empty;
        end else if (pipe_valid_i) begin
            pipe_gnt = 1'b1;
        end else begin
            lu_gnt = ~fifo_empty;
        end
    end

    // Winning write and its enable (rd == 0 optionally suppressed).
    always_comb begin
        gnt_entry = pipe_gnt ? '{rd: pipe_rd_i, data: pipe_data_i} : fifo_head;
`ifdef WB_ARB_X0_FILTER_EN
        gnt_we = (gnt_entry.rd != '0);
`else
        gnt_we = 1'b1;
`endif
    end

    // Starvation count: saturating count of cycles the buffered head loses.
    always_comb begin
        starve_d = '0;
        if (state_q == PIPE_PRI && !fifo_empty && !lu_gnt) begin
            starve_d = (starve_q == '1) ? starve_q : starve_q + 1'b1;
        end
    end

    // Arbiter FSM with registered pipeline ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PIPE_PRI;
            starve_q     <= '0;
            pipe_ready_q <= 1'b1;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                PIPE_PRI: begin
                    if (starve_d == STARVE_LIMIT) begin
                        state_q      <= FORCE_LU;
                        pipe_ready_q <= 1'b0;
                    end
                end
                FORCE_LU: begin
                    state_q      <= PIPE_PRI;
                    pipe_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Register-file write port, one cycle after the grant edge; rd/data hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else if (pipe_gnt || lu_gnt) begin
            rf_we_q   <= gnt_we;
            rf_rd_q   <= gnt_entry.rd;
            rf_data_q <= gnt_entry.data;
        end else begin
            rf_we_q <= 1'b0;
        end
    end

endmodule
